// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle for the serial magnitude comparator.
interface serial_magnitude_comparator_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_eq_B;
    logic             A_lt_B;
    logic             A_gt_B;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, A_eq_B, A_lt_B, A_gt_B
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, A_eq_B, A_lt_B, A_gt_B
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: walks operand bits MSB first, one pair per
// clock, and stops on the first differing pair.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_magnitude_comparator_if.slave bus
);
    localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    logic bit_a_c;
    logic bit_b_c;

    assign bit_a_c = a_q[cnt_q];
    assign bit_b_c = b_q[cnt_q];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            cnt_q   <= MSB_IDX;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = COMPARE;
            COMPARE: if ((bit_a_c != bit_b_c) || (cnt_q == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of datapath and registered outputs
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sm_d   = sm_q;
        cnt_d  = cnt_q;
        eq_d   = eq_q;
        lt_d   = lt_q;
        gt_d   = gt_q;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d   = bus.A;
                    b_d   = bus.B;
                    sm_d  = bus.signed_mode;
                    cnt_d = MSB_IDX;
                    eq_d  = 1'b0;
                    lt_d  = 1'b0;
                    gt_d  = 1'b0;
                end
            end
            COMPARE: begin
                if (bit_a_c != bit_b_c) begin
                    // A set sign bit means the smaller two's-complement value
                    if (sm_q && (cnt_q == MSB_IDX)) begin
                        lt_d = bit_a_c;
                        gt_d = bit_b_c;
                    end else begin
                        gt_d = bit_a_c;
                        lt_d = bit_b_c;
                    end
                end else if (cnt_q == '0) begin
                    eq_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.A_eq_B = eq_q;
    assign bus.A_lt_B = lt_q;
    assign bus.A_gt_B = gt_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed-vector bench for serial_magnitude_comparator.
`timescale 1ns/1ps
module tb_serial_magnitude_comparator;
    localparam int unsigned WIDTH = 8;

    // Flag vectors are {eq, lt, gt}
    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_magnitude_comparator_if #(.WIDTH(WIDTH)) sif ();

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] flags();
        return {sif.A_eq_B, sif.A_lt_B, sif.A_gt_B};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands at a falling edge; returns just after the accepting edge
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sm, input bit hold);
        @(negedge clk);
        sif.A           = a;
        sif.B           = b;
        sif.signed_mode = sm;
        sif.start       = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) sif.start = 1'b0;
    endtask

    // Follows a compare from just after acceptance until done; returns in the done cycle
    task automatic collect(input string tag, input logic [2:0] exp_flags,
                           input int exp_n, input bit scramble);
        int n;
        bit bad;
        n   = 0;
        bad = 1'b0;
        @(negedge clk);
        if (sif.busy !== 1'b1 || sif.done !== 1'b0 || flags() !== 3'b000) bad = 1'b1;
        for (int k = 1; k <= int'(WIDTH) + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (scramble) begin
                sif.A           = WIDTH'($urandom);
                sif.B           = WIDTH'($urandom);
                sif.signed_mode = ~sif.signed_mode;
            end
            if (sif.done === 1'b1) begin
                n = k;
                break;
            end
            if (sif.busy !== 1'b1 || flags() !== 3'b000) bad = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_n));
        check({tag, "_flags"}, 32'(flags()), 32'(exp_flags));
        check({tag, "_busy_at_done"}, 32'(sif.busy), 32'd1);
        check({tag, "_in_flight"}, 32'(bad), 32'd0);
    endtask

    initial begin
        bit saw_done;
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        sif.start       = 1'b0;
        sif.signed_mode = 1'b0;
        sif.A           = '0;
        sif.B           = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_done", 32'(sif.done), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(sif.busy), 32'd0);
        check("idle_done", 32'(sif.done), 32'd0);
        check("idle_flags", 32'(flags()), 32'd0);

        // Equal operands: all bits examined, then flags hold while idle
        launch(8'hA5, 8'hA5, 1'b0, 1'b0);
        collect("eq_a5", F_EQ, 8, 1'b0);
        repeat (5) @(negedge clk);
        check("eq_hold_flags", 32'(flags()), 32'(F_EQ));
        check("eq_hold_done", 32'(sif.done), 32'd0);
        check("eq_hold_busy", 32'(sif.busy), 32'd0);

        // MSB early exit, unsigned then signed
        launch(8'h80, 8'h7F, 1'b0, 1'b0);
        collect("msb_uns", F_GT, 1, 1'b0);
        launch(8'h80, 8'h7F, 1'b1, 1'b0);
        collect("msb_sgn", F_LT, 1, 1'b0);

        // Mid-bit difference at bit 3 and its swap
        launch(8'h3C, 8'h34, 1'b0, 1'b0);
        collect("mid_gt", F_GT, 5, 1'b0);
        launch(8'h34, 8'h3C, 1'b0, 1'b0);
        collect("mid_lt", F_LT, 5, 1'b0);

        // Signed, both negative, differing only at the LSB: -2 < -1
        launch(8'hFE, 8'hFF, 1'b1, 1'b0);
        collect("neg_lsb", F_LT, 8, 1'b0);

        // Start held and inputs scrambled mid-compare
        launch(8'h3C, 8'h34, 1'b0, 1'b1);
        collect("held", F_GT, 5, 1'b1);
        sif.A           = 8'h01;
        sif.B           = 8'h02;
        sif.signed_mode = 1'b0;
        @(negedge clk);
        check("after_done_busy", 32'(sif.busy), 32'd0);
        check("after_done_done", 32'(sif.done), 32'd0);
        check("after_done_flags", 32'(flags()), 32'(F_GT));
        // Start still high in the idle cycle after done is accepted
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        collect("b2b", F_LT, 7, 1'b0);

        // Reset mid-compare aborts with no done
        launch(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(sif.busy), 32'd0);
        check("abort_done", 32'(sif.done), 32'd0);
        check("abort_flags", 32'(flags()), 32'd0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (sif.done === 1'b1 || sif.busy === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Multi-bit magnitude comparator built on the team's 1-bit compare stage (eq/lt/gt per bit pair).
- Loads two WIDTH-bit operands and examines one bit pair per clock, MSB first, cascading the 1-bit results.
- Stops early on the first differing bit.
- Delivers registered A_eq_B / A_lt_B / A_gt_B flags with a one-cycle done pulse; sits upstream of control logic needing area-cheap comparisons.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-index counter width.

Ports:
- clk, input, 1, single clock; rising edge.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request a compare; sampled only in IDLE.
- signed_mode, input, 1, 1 = two's-complement compare, 0 = unsigned; latched with the operands on start.
- A, input, WIDTH, operand A; latched on accepted start.
- B, input, WIDTH, operand B; latched on accepted start.
- busy, output, 1, high whenever state ≠ IDLE.
- done, output, 1, one-cycle pulse: result flags are valid.
- A_eq_B, output, 1, registered A == B.
- A_lt_B, output, 1, registered A < B.
- A_gt_B, output, 1, registered A > B.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state → IDLE.
  - busy, done, A_eq_B, A_lt_B and A_gt_B → 0.
  - Operand registers → 0 and bit counter → WIDTH-1.
  - Reset overrides all other inputs, including mid-compare; no done is issued for an aborted compare.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 at an edge latches A, B and signed_mode, sets counter = WIDTH-1, clears all three flags and moves to COMPARE.
  - start=0 holds IDLE; flags keep their last values.
- COMPARE: at each edge, compare bit pair a=A[cnt], b=B[cnt].
  - a≠b, unsigned (or cnt≠WIDTH-1): A_gt_B=a, A_lt_B=b → DONE.
  - a≠b, signed_mode=1 and cnt=WIDTH-1 (sign bit): polarity inverted, so A_lt_B=a, A_gt_B=b → DONE.
  - a==b and cnt==0: A_eq_B=1 → DONE.
  - a==b and cnt>0: cnt decrements; stay in COMPARE.
- DONE: done=1 for exactly this cycle; next edge → IDLE. start is ignored in DONE.
- Latency:
  - Start accepted at edge E0; n = number of bits examined (1..WIDTH).
  - done=1 and flags valid in the cycle following edge En.
  - Worst case (equal operands) is WIDTH+1 cycles from start to done; best case (MSB differs) is 2 cycles.
- Flags:
  - Exactly one flag is high after any completed compare.
  - Flags hold after done until the next accepted start clears them.
  - All flags are 0 between start acceptance and done.
- start while busy=1 is ignored; there is no queueing.
- Changes to A, B or signed_mode after acceptance have no effect on the in-flight compare.
- Back-to-back operation: a start in the cycle after done (state IDLE) is accepted normally.

Test Plan:
- Reset then idle: hold rst_n=0 two cycles, then release → busy=0, done=0, all flags 0; no activity with start=0.
- Equal, unsigned: A=8'hA5, B=8'hA5, start pulse → busy 8 cycles, done in cycle 9 after start, A_eq_B=1, others 0; flags held 5 idle cycles after done.
- Early exit at MSB, unsigned: A=8'h80, B=8'h7F → done 2 cycles after start, A_gt_B=1. Repeat with signed_mode=1 → A_lt_B=1 (-128 < 127).
- Mid-bit difference: A=8'h3C, B=8'h34 (differ at bit 3) → 5 bits examined, done in cycle 6, A_gt_B=1. Swap operands → A_lt_B=1.
- Protocol:
  - start held high and A/B changed during COMPARE → result reflects the original operands, and no second compare starts until IDLE.
  - start asserted in the cycle after done → accepted.
- Reset mid-operation: start A=8'h00, B=8'h00, assert rst_n=0 at cycle 4 → next cycle busy=0, flags 0, and done never pulses for the aborted compare.
